// File: rtl/jtframe_romarb_pkg.sv
// Shared types and sizes for the three-slot SDRAM ROM arbiter.
package jtframe_romarb_pkg;

  localparam int NSLOT    = 3;
  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_READ
  } state_e;

endpackage

// File: rtl/jtframe_romarb_slot.sv
// One ROM slot: single-word cache, hit detect, byte select and miss flag.
// The tag is the full SDRAM word address; it maps one-to-one to the slot address.
module jtframe_romarb_slot
  import jtframe_romarb_pkg::*;
#(
  parameter int                  AW       = 17,
  parameter bit                  BYTE_SEL = 1'b0,
  parameter int                  DW       = 16,
  parameter logic [SDRAM_AW-1:0] OFFSET   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic [AW-1:0]       addr,
  input  logic                downloading,
  input  logic                clr,
  input  logic                fill_we,
  input  logic [SDRAM_AW-1:0] fill_tag,
  input  logic [SDRAM_DW-1:0] fill_data,
  output logic [DW-1:0]       dout,
  output logic                ok,
  output logic                pending,
  output logic [SDRAM_AW-1:0] sdram_addr
);

  localparam int WAW = BYTE_SEL ? AW - 1 : AW;

  logic [WAW-1:0]      waddr;
  logic [SDRAM_AW-1:0] tag_q, tag_d;
  logic [SDRAM_DW-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                hit;

  generate
    if (BYTE_SEL) begin : g_byte
      assign waddr = addr[AW-1:1];
      assign dout  = addr[0] ? data_q[15:8] : data_q[7:0];
    end else begin : g_word
      assign waddr = addr;
      assign dout  = data_q;
    end
  endgenerate

  // Wrap-around modulo 2^22 falls out of the 22-bit sum.
  assign sdram_addr = OFFSET + {{(SDRAM_AW-WAW){1'b0}}, waddr};

  assign hit     = cs && valid_q && (tag_q == sdram_addr);
  assign ok      = hit && !downloading;
  assign pending = cs && !hit;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (fill_we) begin
      tag_d   = fill_tag;
      data_d  = fill_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/jtframe_rom_arb.sv
// Three-slot SDRAM ROM read arbiter with per-slot one-word caches.
// Define JTFRAME_ROMARB_RR_EN for round-robin arbitration; default is fixed priority.
//
// state   | meaning
// IDLE    | pick a pending slot and latch its SDRAM address
// REQ     | sdram_req high until sdram_ack
// WAIT    | wait for data_dst
// READ    | on data_rdy write the winner's cache unless a download intervened
module jtframe_rom_arb
  import jtframe_romarb_pkg::*;
#(
  parameter int                  SLOT0_AW     = 17,
  parameter int                  SLOT1_AW     = 17,
  parameter int                  SLOT2_AW     = 15,
  parameter logic [SDRAM_AW-1:0] SLOT0_OFFSET = 22'h1_0000,
  parameter logic [SDRAM_AW-1:0] SLOT1_OFFSET = 22'h0,
  parameter logic [SDRAM_AW-1:0] SLOT2_OFFSET = 22'h3_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic                slot0_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  output logic [15:0]         slot0_dout,
  output logic                slot0_ok,
  input  logic                slot1_cs,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  output logic [7:0]          slot1_dout,
  output logic                slot1_ok,
  input  logic                slot2_cs,
  input  logic [SLOT2_AW-1:0] slot2_addr,
  output logic [7:0]          slot2_dout,
  output logic                slot2_ok,
  output logic                sdram_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_dst,
  input  logic                data_rdy,
  input  logic [SDRAM_DW-1:0] data_read
);

  state_e              state_q, state_d;
  logic [1:0]          win_q, win_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic                discard_q, discard_d;
  logic                dl_q;
  logic                clr;
  logic [1:0]          pick;
  logic [NSLOT-1:0]    pending;
  logic [NSLOT-1:0]    fill_we;
  logic [SDRAM_AW-1:0] slot_addr [NSLOT];

  assign clr        = downloading && !dl_q;
  assign sdram_req  = (state_q == ST_REQ);
  assign sdram_addr = addr_q;

  jtframe_romarb_slot #(
    .AW(SLOT0_AW), .BYTE_SEL(1'b0), .DW(16), .OFFSET(SLOT0_OFFSET)
  ) u_slot0 (
    .clk(clk), .rst_n(rst_n), .cs(slot0_cs), .addr(slot0_addr),
    .downloading(downloading), .clr(clr), .fill_we(fill_we[0]),
    .fill_tag(addr_q), .fill_data(data_read), .dout(slot0_dout),
    .ok(slot0_ok), .pending(pending[0]), .sdram_addr(slot_addr[0])
  );

  jtframe_romarb_slot #(
    .AW(SLOT1_AW), .BYTE_SEL(1'b1), .DW(8), .OFFSET(SLOT1_OFFSET)
  ) u_slot1 (
    .clk(clk), .rst_n(rst_n), .cs(slot1_cs), .addr(slot1_addr),
    .downloading(downloading), .clr(clr), .fill_we(fill_we[1]),
    .fill_tag(addr_q), .fill_data(data_read), .dout(slot1_dout),
    .ok(slot1_ok), .pending(pending[1]), .sdram_addr(slot_addr[1])
  );

  jtframe_romarb_slot #(
    .AW(SLOT2_AW), .BYTE_SEL(1'b1), .DW(8), .OFFSET(SLOT2_OFFSET)
  ) u_slot2 (
    .clk(clk), .rst_n(rst_n), .cs(slot2_cs), .addr(slot2_addr),
    .downloading(downloading), .clr(clr), .fill_we(fill_we[2]),
    .fill_tag(addr_q), .fill_data(data_read), .dout(slot2_dout),
    .ok(slot2_ok), .pending(pending[2]), .sdram_addr(slot_addr[2])
  );

`ifdef JTFRAME_ROMARB_RR_EN
  logic [1:0] last_q, last_d;

  // Search starts one past the last granted slot.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= NSLOT; i++) begin
      idx = 2'((int'(last_q) + i) % NSLOT);
      if (!found && pending[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && (|pending) && !downloading) last_d = pick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 2'd0;
    else        last_q <= last_d;
  end
`else
  always_comb begin
    if (pending[0])      pick = 2'd0;
    else if (pending[1]) pick = 2'd1;
    else                 pick = 2'd2;
  end
`endif

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    fill_we   = '0;
    case (state_q)
      ST_IDLE: begin
        if ((|pending) && !downloading) begin
          win_d     = pick;
          addr_d    = slot_addr[pick];
          discard_d = 1'b0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ:  if (sdram_ack) state_d = ST_WAIT;
      ST_WAIT: if (data_dst)  state_d = ST_READ;
      ST_READ: begin
        if (data_rdy) begin
          if (!discard_q && !downloading) fill_we[win_q] = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A download seen at any point of a transaction voids its data.
    if (state_q != ST_IDLE && downloading) discard_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_q     <= 2'd0;
      addr_q    <= '0;
      discard_q <= 1'b0;
      dl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      dl_q      <= downloading;
    end
  end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed self-checking bench for jtframe_rom_arb with a hand-driven SDRAM side.
module tb_jtframe_rom_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic        slot0_cs, slot1_cs, slot2_cs;
  logic [16:0] slot0_addr, slot1_addr;
  logic [14:0] slot2_addr;
  logic [15:0] slot0_dout;
  logic [7:0]  slot1_dout, slot2_dout;
  logic        slot0_ok, slot1_ok, slot2_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack, data_dst, data_rdy;
  logic [15:0] data_read;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtframe_rom_arb dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_dout(slot0_dout), .slot0_ok(slot0_ok),
    .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_dout(slot1_dout), .slot1_ok(slot1_ok),
    .slot2_cs(slot2_cs), .slot2_addr(slot2_addr), .slot2_dout(slot2_dout), .slot2_ok(slot2_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read)
  );

  task automatic wait_req(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (sdram_req) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called at a negedge with sdram_req high; returns at the negedge after the fill edge.
  task automatic serve(input logic [15:0] d);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    data_dst  = 1'b1;
    @(negedge clk);
    data_dst  = 1'b0;
    data_rdy  = 1'b1;
    data_read = d;
    @(negedge clk);
    data_rdy  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; downloading = 1'b0;
    slot0_cs = 0; slot1_cs = 0; slot2_cs = 0;
    slot0_addr = '0; slot1_addr = '0; slot2_addr = '0;
    sdram_ack = 0; data_dst = 0; data_rdy = 0; data_read = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", sdram_req); end
    n_cmp++; if (sdram_addr !== 22'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", sdram_addr); end
    n_cmp++; if ({slot0_ok, slot1_ok, slot2_ok} !== 3'b000) begin n_err++; $display("FAIL rst_ok got=%b exp=000", {slot0_ok, slot1_ok, slot2_ok}); end
    n_cmp++; if (slot0_dout !== 16'h0) begin n_err++; $display("FAIL rst_dout got=%h exp=0", slot0_dout); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL rst_rel_req got=%b exp=0", sdram_req); end
  endtask

  task automatic test_miss_fill;
    slot1_cs = 1'b1; slot1_addr = 17'h0005;
    #1;
    n_cmp++; if (slot1_ok !== 1'b0) begin n_err++; $display("FAIL miss_ok_cold got=%b exp=0", slot1_ok); end
    @(negedge clk);
    n_cmp++; if (sdram_req !== 1'b1) begin n_err++; $display("FAIL miss_req got=%b exp=1", sdram_req); end
    n_cmp++; if (sdram_addr !== 22'h2) begin n_err++; $display("FAIL miss_addr got=%h exp=000002", sdram_addr); end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL req_after_ack got=%b exp=0", sdram_req); end
    data_dst = 1'b1;
    @(negedge clk);
    data_dst = 1'b0; data_rdy = 1'b1; data_read = 16'hA55A;
    @(negedge clk);
    data_rdy = 1'b0;
    n_cmp++; if (slot1_ok !== 1'b1) begin n_err++; $display("FAIL fill_ok got=%b exp=1", slot1_ok); end
    n_cmp++; if (slot1_dout !== 8'hA5) begin n_err++; $display("FAIL fill_dout got=%h exp=a5", slot1_dout); end
  endtask

  task automatic test_hit;
    slot1_addr = 17'h0004;
    #1;
    n_cmp++; if (slot1_ok !== 1'b1) begin n_err++; $display("FAIL hit_ok got=%b exp=1", slot1_ok); end
    n_cmp++; if (slot1_dout !== 8'h5A) begin n_err++; $display("FAIL hit_dout got=%h exp=5a", slot1_dout); end
    @(negedge clk);
    n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL hit_noreq got=%b exp=0", sdram_req); end
    slot1_cs = 1'b0;
  endtask

  task automatic test_priority;
    bit got;
    slot0_cs = 1'b1; slot0_addr = 17'h3;
    slot2_cs = 1'b1; slot2_addr = 15'h11;
    @(negedge clk);
`ifdef JTFRAME_ROMARB_RR_EN
    n_cmp++; if (sdram_addr !== 22'h3_0008) begin n_err++; $display("FAIL prio_first got=%h exp=030008", sdram_addr); end
    serve(16'h1234);
    n_cmp++; if (slot2_ok !== 1'b1 || slot2_dout !== 8'h12) begin n_err++; $display("FAIL prio_first_fill got=%b/%h exp=1/12", slot2_ok, slot2_dout); end
    n_cmp++; if (slot0_ok !== 1'b0) begin n_err++; $display("FAIL prio_second_pend got=%b exp=0", slot0_ok); end
    wait_req(10, got);
    n_cmp++; if (!got || sdram_addr !== 22'h1_0003) begin n_err++; $display("FAIL prio_second got=%0d/%h exp=1/010003", got, sdram_addr); end
    serve(16'hBEEF);
    n_cmp++; if (slot0_ok !== 1'b1 || slot0_dout !== 16'hBEEF) begin n_err++; $display("FAIL prio_second_fill got=%b/%h exp=1/beef", slot0_ok, slot0_dout); end
    n_cmp++; if (slot2_ok !== 1'b1) begin n_err++; $display("FAIL prio_both_ok got=%b exp=1", slot2_ok); end
    // Later tests assume slot2 holds 8'hBE-style data only via ok; refetch keeps expectations uniform.
`else
    n_cmp++; if (sdram_addr !== 22'h1_0003) begin n_err++; $display("FAIL prio_first got=%h exp=010003", sdram_addr); end
    serve(16'h1234);
    n_cmp++; if (slot0_ok !== 1'b1 || slot0_dout !== 16'h1234) begin n_err++; $display("FAIL prio_first_fill got=%b/%h exp=1/1234", slot0_ok, slot0_dout); end
    n_cmp++; if (slot2_ok !== 1'b0) begin n_err++; $display("FAIL prio_second_pend got=%b exp=0", slot2_ok); end
    wait_req(10, got);
    n_cmp++; if (!got || sdram_addr !== 22'h3_0008) begin n_err++; $display("FAIL prio_second got=%0d/%h exp=1/030008", got, sdram_addr); end
    serve(16'hBEEF);
    n_cmp++; if (slot2_ok !== 1'b1 || slot2_dout !== 8'hBE) begin n_err++; $display("FAIL prio_second_fill got=%b/%h exp=1/be", slot2_ok, slot2_dout); end
    n_cmp++; if (slot0_ok !== 1'b1) begin n_err++; $display("FAIL prio_both_ok got=%b exp=1", slot0_ok); end
`endif
    slot0_cs = 1'b0; slot2_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_change;
    bit got;
    slot0_cs = 1'b1; slot0_addr = 17'h10;
    wait_req(5, got);
    n_cmp++; if (!got || sdram_addr !== 22'h1_0010) begin n_err++; $display("FAIL chg_req got=%0d/%h exp=1/010010", got, sdram_addr); end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    slot0_addr = 17'h20;
    data_dst = 1'b1;
    @(negedge clk);
    data_dst = 1'b0; data_rdy = 1'b1; data_read = 16'hCAFE;
    @(negedge clk);
    data_rdy = 1'b0;
    n_cmp++; if (slot0_ok !== 1'b0) begin n_err++; $display("FAIL chg_ok_new got=%b exp=0", slot0_ok); end
    slot0_addr = 17'h10;
    #1;
    n_cmp++; if (slot0_ok !== 1'b1 || slot0_dout !== 16'hCAFE) begin n_err++; $display("FAIL chg_tag_old got=%b/%h exp=1/cafe", slot0_ok, slot0_dout); end
    slot0_addr = 17'h20;
    wait_req(5, got);
    n_cmp++; if (!got || sdram_addr !== 22'h1_0020) begin n_err++; $display("FAIL chg_rereq got=%0d/%h exp=1/010020", got, sdram_addr); end
    serve(16'h0F0F);
    n_cmp++; if (slot0_ok !== 1'b1 || slot0_dout !== 16'h0F0F) begin n_err++; $display("FAIL chg_fill got=%b/%h exp=1/0f0f", slot0_ok, slot0_dout); end
  endtask

  task automatic test_download;
    bit got;
    slot1_cs = 1'b1; slot1_addr = 17'h4;
    slot2_cs = 1'b1; slot2_addr = 15'h11;
    #1;
    n_cmp++; if ({slot0_ok, slot1_ok, slot2_ok} !== 3'b111) begin n_err++; $display("FAIL dl_pre_ok got=%b exp=111", {slot0_ok, slot1_ok, slot2_ok}); end
    downloading = 1'b1;
    #1;
    n_cmp++; if ({slot0_ok, slot1_ok, slot2_ok} !== 3'b000) begin n_err++; $display("FAIL dl_ok got=%b exp=000", {slot0_ok, slot1_ok, slot2_ok}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL dl_noreq[%0d] got=%b exp=0", i, sdram_req); end
    end
    downloading = 1'b0;
    #1;
    n_cmp++; if ({slot0_ok, slot1_ok, slot2_ok} !== 3'b000) begin n_err++; $display("FAIL dl_after_miss got=%b exp=000", {slot0_ok, slot1_ok, slot2_ok}); end
    slot1_cs = 1'b0; slot2_cs = 1'b0;
    wait_req(5, got);
    n_cmp++; if (!got || sdram_addr !== 22'h1_0020) begin n_err++; $display("FAIL dl_refetch got=%0d/%h exp=1/010020", got, sdram_addr); end
    serve(16'h5555);
    n_cmp++; if (slot0_ok !== 1'b1 || slot0_dout !== 16'h5555) begin n_err++; $display("FAIL dl_refill got=%b/%h exp=1/5555", slot0_ok, slot0_dout); end
    slot0_cs = 1'b0;
  endtask

  task automatic test_download_mid;
    bit got;
    slot2_cs = 1'b1; slot2_addr = 15'h11;
    wait_req(5, got);
    n_cmp++; if (!got || sdram_addr !== 22'h3_0008) begin n_err++; $display("FAIL dlm_req got=%0d/%h exp=1/030008", got, sdram_addr); end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    downloading = 1'b1;
    @(negedge clk);
    downloading = 1'b0;
    data_dst = 1'b1;
    @(negedge clk);
    data_dst = 1'b0; data_rdy = 1'b1; data_read = 16'h7788;
    @(negedge clk);
    data_rdy = 1'b0;
    n_cmp++; if (slot2_ok !== 1'b0) begin n_err++; $display("FAIL dlm_discard got=%b exp=0", slot2_ok); end
    wait_req(5, got);
    n_cmp++; if (!got || sdram_addr !== 22'h3_0008) begin n_err++; $display("FAIL dlm_rereq got=%0d/%h exp=1/030008", got, sdram_addr); end
    serve(16'h7788);
    n_cmp++; if (slot2_ok !== 1'b1 || slot2_dout !== 8'h77) begin n_err++; $display("FAIL dlm_fill got=%b/%h exp=1/77", slot2_ok, slot2_dout); end
  endtask

  task automatic test_reset_mid;
    bit got;
    slot1_cs = 1'b1; slot1_addr = 17'h40;
    wait_req(5, got);
    n_cmp++; if (!got || sdram_addr !== 22'h20) begin n_err++; $display("FAIL rm_req got=%0d/%h exp=1/000020", got, sdram_addr); end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    n_cmp++; if (slot2_ok !== 1'b1) begin n_err++; $display("FAIL rm_pre_ok got=%b exp=1", slot2_ok); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sdram_req !== 1'b0 || sdram_addr !== 22'h0) begin n_err++; $display("FAIL rm_req_now got=%b/%h exp=0/000000", sdram_req, sdram_addr); end
    n_cmp++; if ({slot0_ok, slot1_ok, slot2_ok} !== 3'b000) begin n_err++; $display("FAIL rm_ok_now got=%b exp=000", {slot0_ok, slot1_ok, slot2_ok}); end
    data_dst = 1'b1; data_rdy = 1'b1; data_read = 16'h9999;
    repeat (2) @(negedge clk);
    data_dst = 1'b0; data_rdy = 1'b0;
    slot1_cs = 1'b0; slot2_cs = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL rm_idle got=%b exp=0", sdram_req); end
    slot1_cs = 1'b1; slot2_cs = 1'b1;
    #1;
    n_cmp++; if ({slot1_ok, slot2_ok} !== 2'b00) begin n_err++; $display("FAIL rm_nofill got=%b exp=00", {slot1_ok, slot2_ok}); end
    wait_req(5, got);
    n_cmp++; if (!got || sdram_addr !== 22'h20) begin n_err++; $display("FAIL rm_after got=%0d/%h exp=1/000020", got, sdram_addr); end
    serve(16'h1111);
    n_cmp++; if (slot1_ok !== 1'b1 || slot1_dout !== 8'h11) begin n_err++; $display("FAIL rm_fill got=%b/%h exp=1/11", slot1_ok, slot1_dout); end
    slot1_cs = 1'b0; slot2_cs = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_priority();
    test_addr_change();
    test_download();
    test_download_mid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtframe_rom_arb.md
JTFRAME_ROM_ARB -- requirements
Module: jtframe_rom_arb

Interface
REQ-001 Parameters: SLOT0_AW 17, gfx slot address width (16-bit words). SLOT1_AW 17, main slot byte-address width. SLOT2_AW 15, sound slot byte-address width.
REQ-002 Parameters: SLOT0_OFFSET 22'h1_0000, SLOT1_OFFSET 0, SLOT2_OFFSET 22'h3_0000; each is the SDRAM word offset of its slot.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 downloading  in  1  ROM load in progress.
REQ-006 slotN_cs  in  1  slot N read request, N=0..2.
REQ-007 slotN_addr  in  SLOTN_AW  slot N address.
REQ-008 slot0_dout  out  16  gfx data; slot1_dout, slot2_dout  out  8  byte data.
REQ-009 slotN_ok  out  1  slotN_dout is valid for the current slotN_addr.
REQ-010 sdram_req  out  1; sdram_addr  out  22; sdram_ack  in  1; data_dst  in  1; data_rdy  in  1; data_read  in  16.

Function
REQ-011 Word address: slot0 = addr; slots 1/2 = addr[AW-1:1]; sdram_addr = SLOTN_OFFSET + word address, 22-bit, wrap-around modulo 2^22.
REQ-012 Byte select: slots 1/2 output data_read[7:0] when addr[0]=0 and data_read[15:8] when addr[0]=1, taken from the cached word.
REQ-013 Each slot holds a one-word cache: tag, data and valid bit.
REQ-014 Hit: slotN_ok is combinationally high when cs=1, valid=1 and the word address equals the tag, with zero latency.
REQ-015 slotN_ok is low whenever cs=0 or downloading=1.
REQ-016 Miss: the slot is pending when cs=1 and there is no hit.
REQ-017 FSM states IDLE, REQ, WAIT, READ.
REQ-018 IDLE: when one or more slots are pending and downloading=0, the FSM latches the winner and its sdram_addr, then goes to REQ on the next edge.
REQ-019 REQ: sdram_req=1 and is held until sdram_ack. The FSM moves to WAIT on the cycle after ack, with sdram_req low in that cycle.
REQ-020 WAIT: the FSM waits for data_dst, then goes to READ.
REQ-021 READ: on data_rdy, data_read is written to the winner's cache with the tag of the issued address and valid=1. The FSM returns to IDLE, and ok is visible on the next cycle if the address is unchanged.
REQ-022 If cs falls or the address changes mid-transaction, the transaction still completes and fills the cache for the issued address; no abort is ever issued.
REQ-023 Arbitration is fixed priority, slot0 > slot1 > slot2, unless REQ-031 applies.
REQ-024 A simultaneous hit on one slot and a fill on another are both served in the same cycle.
REQ-025 A rising edge of downloading clears all valid bits; during download the FSM stays in IDLE and sdram_req=0.
REQ-026 If downloading rises mid-transaction, the FSM finishes the current handshake and discards the data (valid stays 0).

Reset
REQ-027 On rst_n low: FSM=IDLE, sdram_req=0, sdram_addr=0, all valid=0, all tags=0, all cache data=0, all ok=0.
REQ-028 Reset takes effect immediately without a clock; release is synchronous to clk.
REQ-029 Reset asserted mid-transaction abandons it; no cache fill follows.

Configuration
REQ-030 Macro JTFRAME_ROMARB_RR_EN.
REQ-031 Defined: round-robin arbitration; priority starts after the last granted slot, and the rotation pointer resets to slot0.
REQ-032 Undefined: fixed priority per REQ-023, with no rotation pointer logic.

Structure
REQ-033 Package jtframe_romarb_pkg holds:
- FSM state enum;
- NSLOT=3;
- SDRAM address width 22 and data width 16.
REQ-034 Sub-module jtframe_romarb_slot provides the per-slot cache, tag compare, byte select and pending flag, instanced three times; the top holds the FSM and arbiter.

Verification
REQ-035 slot1 cs, addr 17'h0005, cold cache:
- sdram_req next cycle; sdram_addr=22'h2;
- after ack/dst/rdy with data_read=16'hA55A, slot1_dout=8'hA5 and slot1_ok=1.
REQ-036 Then addr 17'h0004 -> slot1_ok=1 the same cycle, dout=8'h5A, no sdram_req.
REQ-037 slot0 and slot2 cs in the same cycle, both misses -> slot0 served first at sdram_addr=22'h1_0000+addr; slot2 is served afterwards. With JTFRAME_ROMARB_RR_EN and last grant=0, slot2 is first.
REQ-038 slot0 addr changes from 17'h10 to 17'h20 while in WAIT -> cache fills tag 17'h10 with ok=0, then a new request goes out for 22'h1_0020.
REQ-039 downloading pulses high after caches are filled -> all ok=0 and no sdram_req while high; the next cs afterwards misses.
REQ-040 rst_n low in WAIT -> sdram_req=0 and all ok=0 immediately; after release the FSM is in IDLE.
